// File: rtl/divider_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | divider_pkg                                                        |
// | Divide opcodes, divider state encoding and counter width.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package divider_pkg;

  localparam int EXU_OPT_WIDTH = 5;

  localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIV   = 5'd16;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVU  = 5'd17;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_REM   = 5'd18;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMU  = 5'd19;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVW  = 5'd20;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_DIVUW = 5'd21;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMW  = 5'd22;
  localparam logic [EXU_OPT_WIDTH-1:0] ALU_REMUW = 5'd23;

  localparam int DIV_CNT_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | divider                                                            |
// | Radix-2 restoring divider for RV64M DIV/REM and their W variants.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module divider
  import divider_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CPU_WIDTH-1:0]     i_src1,
  input  logic [CPU_WIDTH-1:0]     i_src2,
  input  logic [EXU_OPT_WIDTH-1:0] i_opt,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CPU_WIDTH-1:0]     o_result
);

  localparam int HW = 32;
  localparam int SH = CPU_WIDTH - HW;
  localparam logic [CPU_WIDTH-1:0]     C_ZERO   = '0;
  localparam logic [CPU_WIDTH-1:0]     C_ONES   = '1;
  localparam logic [CPU_WIDTH-1:0]     C_MIN    = {1'b1, {(CPU_WIDTH-1){1'b0}}};
  localparam logic [DIV_CNT_WIDTH-1:0] C_LAST_W = DIV_CNT_WIDTH'(HW - 1);
  localparam logic [DIV_CNT_WIDTH-1:0] C_LAST_D = DIV_CNT_WIDTH'(CPU_WIDTH - 1);

  function automatic logic [CPU_WIDTH-1:0] f_sext32(input logic [CPU_WIDTH-1:0] x);
    return {{SH{x[HW-1]}}, x[HW-1:0]};
  endfunction

  function automatic logic [CPU_WIDTH-1:0] f_zext32(input logic [CPU_WIDTH-1:0] x);
    return {{SH{1'b0}}, x[HW-1:0]};
  endfunction

  function automatic logic [CPU_WIDTH-1:0] f_neg_if(input logic neg, input logic [CPU_WIDTH-1:0] x);
    return neg ? (C_ZERO - x) : x;
  endfunction

  div_state_e                 r_state, w_state_nx;
  logic [DIV_CNT_WIDTH-1:0]   r_cnt;
  logic [CPU_WIDTH-1:0]       r_rem, r_quo, r_dvs, r_result;
  logic                       r_qneg, r_rneg, r_is_rem, r_is_w;

  logic                       w_known, w_is_w, w_signed, w_is_rem;
  logic [CPU_WIDTH-1:0]       w_a, w_b, w_abs_a, w_abs_b, w_spec_res;
  logic                       w_s1, w_s2, w_div0, w_ovf, w_special, w_accept;
  logic [CPU_WIDTH:0]         w_rem_sh, w_diff;
  logic                       w_ge, w_last;
  logic [CPU_WIDTH-1:0]       w_rem_nx, w_quo_nx, w_fin;

  // Opcode decode and operand preparation
  always_comb begin
    w_known  = 1'b1;
    w_is_w   = 1'b0;
    w_signed = 1'b0;
    w_is_rem = 1'b0;
    case (i_opt)
      ALU_DIV:   begin w_signed = 1'b1; end
      ALU_DIVU:  begin end
      ALU_REM:   begin w_signed = 1'b1; w_is_rem = 1'b1; end
      ALU_REMU:  begin w_is_rem = 1'b1; end
      ALU_DIVW:  begin w_is_w = 1'b1; w_signed = 1'b1; end
      ALU_DIVUW: begin w_is_w = 1'b1; end
      ALU_REMW:  begin w_is_w = 1'b1; w_signed = 1'b1; w_is_rem = 1'b1; end
      ALU_REMUW: begin w_is_w = 1'b1; w_is_rem = 1'b1; end
      default:   begin w_known = 1'b0; end
    endcase

    w_a = i_src1;
    w_b = i_src2;
    if (w_is_w) begin
      w_a = w_signed ? f_sext32(i_src1) : f_zext32(i_src1);
      w_b = w_signed ? f_sext32(i_src2) : f_zext32(i_src2);
    end
    w_s1    = w_signed & w_a[CPU_WIDTH-1];
    w_s2    = w_signed & w_b[CPU_WIDTH-1];
    w_abs_a = f_neg_if(w_s1, w_a);
    w_abs_b = f_neg_if(w_s2, w_b);

    // After W sign extension the most-negative 32-bit value equals f_sext32(C_MIN >> SH)
    w_div0 = (w_b == C_ZERO);
    w_ovf  = w_signed && (w_b == C_ONES) &&
             (w_a == (w_is_w ? f_sext32(C_MIN >> SH) : C_MIN));
    w_special = !w_known || w_div0 || w_ovf;

    w_spec_res = C_ZERO;
    if (w_known && w_div0)
      w_spec_res = w_is_rem ? w_a : C_ONES;
    else if (w_known && w_ovf)
      w_spec_res = w_is_rem ? C_ZERO : w_a;
    if (w_is_w)
      w_spec_res = f_sext32(w_spec_res);
  end

  assign w_accept = (r_state == IDLE) && i_valid && !i_flush;

  // One restoring step; the borrow of the N+1-bit subtraction is the compare
  always_comb begin
    w_rem_sh = {r_rem, r_quo[CPU_WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_dvs};
    w_ge     = !w_diff[CPU_WIDTH];
    w_rem_nx = w_ge ? w_diff[CPU_WIDTH-1:0] : w_rem_sh[CPU_WIDTH-1:0];
    w_quo_nx = {r_quo[CPU_WIDTH-2:0], w_ge};
    w_last   = (r_cnt == (r_is_w ? C_LAST_W : C_LAST_D));
    w_fin    = r_is_rem ? f_neg_if(r_rneg, w_rem_nx) : f_neg_if(r_qneg, w_quo_nx);
    if (r_is_w)
      w_fin = f_sext32(w_fin);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_state_nx = w_special ? DONE : CALC;
      CALC:    if (w_last) w_state_nx = DONE;
      DONE:    if (i_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (i_flush)
      w_state_nx = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_is_rem <= 1'b0;
      r_is_w   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      // W dividends are left-aligned so every step consumes the MSB
      r_quo    <= w_is_w ? {w_abs_a[HW-1:0], {SH{1'b0}}} : w_abs_a;
      r_dvs    <= w_abs_b;
      r_qneg   <= w_s1 ^ w_s2;
      r_rneg   <= w_s1;
      r_is_rem <= w_is_rem;
      r_is_w   <= w_is_w;
      if (w_special)
        r_result <= w_spec_res;
    end else if (r_state == CALC && !i_flush) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last)
        r_result <= w_fin;
    end
  end

  assign o_ready  = (r_state == IDLE);
  assign o_valid  = (r_state == DONE);
  assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_divider                                                         |
// | Directed and random checks of divider against an arithmetic model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_divider;
  import divider_pkg::*;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_flush = 1'b0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic [63:0]              i_src1 = '0;
  logic [63:0]              i_src2 = '0;
  logic [EXU_OPT_WIDTH-1:0] i_opt = '0;
  logic                     o_valid;
  logic                     i_ready = 1'b0;
  logic [63:0]              o_result;

  int n_tests = 0;
  int n_fail  = 0;

  divider #(.CPU_WIDTH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_src1(i_src1), .i_src2(i_src2), .i_opt(i_opt),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference results straight from the RISC-V M-extension rules
  function automatic logic [63:0] ref_model(input logic [4:0] opt, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int wa, wb;
    logic [31:0] ua, ub;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (opt)
      ALU_DIV:   if (sb == 0) return '1; else if (a == 64'h8000_0000_0000_0000 && sb == -1) return a; else return sa / sb;
      ALU_REM:   if (sb == 0) return a;  else if (a == 64'h8000_0000_0000_0000 && sb == -1) return 0; else return sa % sb;
      ALU_DIVU:  if (b == 0) return '1; else return a / b;
      ALU_REMU:  if (b == 0) return a;  else return a % b;
      ALU_DIVW:  if (wb == 0) return '1; else if (ua == 32'h8000_0000 && wb == -1) return sx32(ua); else return sx32(32'(wa / wb));
      ALU_REMW:  if (wb == 0) return sx32(ua); else if (ua == 32'h8000_0000 && wb == -1) return 0; else return sx32(32'(wa % wb));
      ALU_DIVUW: if (ub == 0) return '1; else return sx32(ua / ub);
      ALU_REMUW: if (ub == 0) return sx32(ua); else return sx32(ua % ub);
      default:   return 0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] opt, input logic [63:0] a, input logic [63:0] b);
    case (opt)
      ALU_DIV, ALU_REM:
        return (b == 0 || (a == 64'h8000_0000_0000_0000 && b == '1)) ? 1 : 65;
      ALU_DIVU, ALU_REMU:
        return (b == 0) ? 1 : 65;
      ALU_DIVW, ALU_REMW:
        return (b[31:0] == 0 || (a[31:0] == 32'h8000_0000 && b[31:0] == '1)) ? 1 : 33;
      ALU_DIVUW, ALU_REMUW:
        return (b[31:0] == 0) ? 1 : 33;
      default:
        return 1;
    endcase
  endfunction

  // Issue one request, wait for the response, hold it, then retire it
  task automatic run_op(input string tag, input logic [4:0] opt, input logic [63:0] a,
                        input logic [63:0] b, input int hold, output logic [63:0] got);
    logic [63:0] exp;
    int lat, k;
    exp = ref_model(opt, a, b);
    lat = ref_latency(opt, a, b);
    @(negedge i_clk);
    check({tag, "_ready_in"}, 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_opt = opt; i_src1 = a; i_src2 = b;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (!o_valid && k < 200);
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_result"}, o_result, exp);
    got = o_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
      check({tag, "_hold_result"}, o_result, got);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    @(negedge i_clk);
    check({tag, "_ready_out"}, 64'(o_ready), 64'd1);
    check({tag, "_valid_out"}, 64'(o_valid), 64'd0);
  endtask

  logic [4:0] opts [0:8];
  logic [63:0] got, ra, rb;
  int k, sel;
  bit seen;

  initial begin
    opts = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW, 5'd3};

    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_result", o_result, 64'd0);

    run_op("div_neg", ALU_DIV, 64'd100, -64'sd7, 5, got);
    check("div_neg_const", got, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("rem_neg", ALU_REM, 64'd100, -64'sd7, 5, got);
    check("rem_neg_const", got, 64'd2);
    run_op("divu_zero", ALU_DIVU, 64'h1234, 64'd0, 0, got);
    check("divu_zero_const", got, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", ALU_REMU, 64'h1234, 64'd0, 0, got);
    check("remu_zero_const", got, 64'h1234);
    run_op("div_ovf", ALU_DIV, 64'h8000_0000_0000_0000, '1, 1, got);
    check("div_ovf_const", got, 64'h8000_0000_0000_0000);
    run_op("remw_ovf", ALU_REMW, 64'hFFFF_FFFF_8000_0000, '1, 1, got);
    check("remw_ovf_const", got, 64'd0);
    run_op("divuw", ALU_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 2, got);
    check("divuw_const", got, 64'h0000_0000_7FFF_FFFF);
    run_op("remw_neg", ALU_REMW, -64'sd7, 64'd2, 0, got);
    check("remw_neg_const", got, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("bad_opt", 5'd3, 64'd55, 64'd5, 0, got);
    check("bad_opt_const", got, 64'd0);

    // Flush in cycle T+10 of a 64-bit DIV, new DIVU accepted in T+12
    @(negedge i_clk);
    i_valid = 1'b1; i_opt = ALU_DIV; i_src1 = 64'd1000; i_src2 = 64'd7;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    if (o_valid) seen = 1'b1;
    check("flush_no_valid", 64'(seen), 64'd0);
    check("flush_ready", 64'(o_ready), 64'd1);
    run_op("after_flush", ALU_DIVU, 64'd10, 64'd3, 0, got);
    check("after_flush_const", got, 64'd3);

    // Reset while a result is pending
    @(negedge i_clk);
    i_valid = 1'b1; i_opt = ALU_DIVU; i_src1 = 64'h77; i_src2 = 64'd0;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(negedge i_clk);
    check("pre_rst_valid", 64'(o_valid), 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_done_valid", 64'(o_valid), 64'd0);
    check("rst_done_result", o_result, 64'd0);
    check("rst_done_ready", 64'(o_ready), 64'd1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      ra = {$urandom, $urandom};
      if (sel == 0) ra = 64'h8000_0000_0000_0000;
      if (sel == 1) ra = 64'hFFFF_FFFF_8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 64'd0;
        1:       rb = '1;
        2:       rb = 64'($urandom_range(1, 20));
        3:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      run_op("rand", opts[$urandom_range(0, 8)], ra, rb, $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
